program_counter_unit: RTL
=========================

Name: program_counter_unit

Overview:
- Parametrised next-generation program counter for the datapath fetch stage. Adds the following:
  - boot handshake
  - stall hold
  - branch/jump redirect
  - trap vectoring with misalignment detection
  - small circular return-address stack (RAS) for call/return prediction
- Drives the instruction memory address and exports PC+INC to the adder/writeback mux.

Parameters:
XLEN, 32, width of PC and all address ports
RESET_VECTOR, 32'h0000_0000, PC value held in reset and during BOOT
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect
INC, 4, sequential increment in bytes
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clock  input  1  rising-edge clock from datapath
reset  input  1  asynchronous, active-high reset
stall  input  1  hold PC (hazard unit)
redirect_valid  input  1  taken branch/jump this cycle
redirect_target  input  XLEN  branch/jump target address
trap  input  1  exception request
ras_push  input  1  call decoded at current PC; push pc+INC
ras_pop  input  1  return decoded; predict PC from RAS top
pc  output  XLEN  current PC to instruction memory
pc_plus_inc  output  XLEN  combinational pc+INC, modulo 2^XLEN
pc_valid  output  1  PC is fetchable
misaligned  output  1  one-cycle pulse: last accepted redirect target misaligned
ras_empty  output  1  RAS count == 0
ras_full  output  1  RAS count == RAS_DEPTH

Behaviour:
- Reset state (asynchronous, immediate while reset high):
  - pc=RESET_VECTOR, pc_valid=0, misaligned=0
  - RAS count=0, top pointer=0, ras_empty=1, ras_full=0, state=BOOT
- FSM has two states:
  - BOOT: on the first rising edge with reset low, go to RUN and set pc_valid=1. pc stays RESET_VECTOR. All inputs are ignored in BOOT.
  - RUN: remains until reset.
- Next-PC priority in RUN, highest first:
  1. trap -> pc=TRAP_VECTOR; RAS flushed (count=0).
  2. redirect_valid with redirect_target[1:0]!=0 -> pc=TRAP_VECTOR, misaligned=1 next cycle, RAS flushed.
  3. redirect_valid (aligned) -> pc=redirect_target.
  4. stall -> pc held.
  5. ras_pop with RAS non-empty -> pc=RAS top entry.
  6. Otherwise -> pc=pc+INC, wrapping modulo 2^XLEN (all-ones region wraps to 0).
- Trap and redirect override stall: a redirect is never lost.
- misaligned is a registered pulse, high exactly one cycle after the offending edge; otherwise 0.
- RAS update:
  - Only when RUN, !stall, !trap and !redirect_valid; otherwise RAS unchanged (except the flushes above).
  - Push only: write pc+INC at top+1; top++ (wraps modulo RAS_DEPTH).
    - count++ saturating at RAS_DEPTH.
    - Push when full overwrites the oldest entry; ras_full stays 1.
  - Pop only, non-empty: top--, count--. Pop on empty is ignored and PC advances sequentially (item 6).
  - Push and pop same cycle:
    - If non-empty: pc=old top; top entry overwritten with pc+INC; count unchanged.
    - If empty: treated as push only; PC sequential.
- ras_empty and ras_full are derived from registered count; no combinational path from inputs.
- Latency: all pc changes visible one clock after the inputs are sampled. pc_plus_inc follows pc combinationally.
- Reset asserted mid-operation immediately restores the reset state, discarding RAS contents.

Decomposition:
- Shared package pc_pkg:
  - pc_state_t enum {BOOT, RUN}
  - next-PC select enum {SEL_TRAP, SEL_REDIR, SEL_HOLD, SEL_RAS, SEL_SEQ}
  - default TRAP_VECTOR/RESET_VECTOR constants
- One sub-module: return_address_stack. It owns the circular storage, top pointer, saturating count, push/pop/flush ports and empty/full flags.
- program_counter_unit keeps the FSM, priority mux and misaligned register.

Test Plan:
- Reset and boot: assert reset mid-run at pc=0x40 -> pc=0, pc_valid=0 immediately. After release, first edge keeps pc=0 with pc_valid=1; next edges give 4, 8, 12.
- Stall and redirect: stall for 3 cycles at pc=0x10 -> pc stays 0x10. redirect_valid=1 with target 0x80 while stall=1 -> pc=0x80 next cycle.
- Misalignment and trap: redirect to 0x82 -> pc=0x100, misaligned=1 for exactly one cycle, ras_empty=1. trap at pc=0x200 -> pc=0x100.
- RAS call/return: push at pc=0x20 and at pc=0x40 (entries 0x24, 0x44), then pop, pop -> pc=0x44, then 0x24. Third pop on empty -> sequential pc+4, ras_empty=1.
- RAS overflow (RAS_DEPTH=4): pushes at pc 0x0, 0x4, 0x8, 0xC, 0x10 -> ras_full=1. Five pops return 0x14, 0x10, 0xC, 0x8, then sequential (0x4 was overwritten).
- Wrap and simultaneous events:
  - pc=0xFFFF_FFFC sequential -> pc=0, pc_plus_inc=0x4 at pc=0.
  - push+pop with top=0x44 at pc=0x60 -> pc=0x44, top becomes 0x64, count unchanged.

Source files
------------

// File: rtl/pc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared types and default vectors for the fetch-stage program
//               counter and its return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    // Two-state sequencer: BOOT holds the reset vector for one edge, then RUN.
    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } pc_state_t;

    // Next-PC source, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        SEL_TRAP  = 3'd0,
        SEL_REDIR = 3'd1,
        SEL_HOLD  = 3'd2,
        SEL_RAS   = 3'd3,
        SEL_SEQ   = 3'd4
    } pc_sel_t;

    localparam logic [31:0] c_default_reset_vector = 32'h0000_0000;
    localparam logic [31:0] c_default_trap_vector  = 32'h0000_0100;

    // Instruction addresses must be word aligned; any set low bit is a fault.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage : pc_pkg
`default_nettype wire

// File: rtl/return_address_stack.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : return_address_stack
// Description : Small circular return-address stack. Push writes above the
//               top, pop drops the top, push+pop replaces the top in place.
//               A push when full silently overwrites the oldest entry.
// Revision    : 1.0 - initial release
// ============================================================================
module return_address_stack #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top_data,
    output logic            empty,
    output logic            full
);

    localparam int unsigned      c_ptr_w     = $clog2(RAS_DEPTH);
    localparam int unsigned      c_cnt_w     = $clog2(RAS_DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_max_count = c_cnt_w'(RAS_DEPTH);

    logic [XLEN-1:0]    r_mem [RAS_DEPTH];
    logic [c_ptr_w-1:0] r_top;
    logic [c_cnt_w-1:0] r_count;

    logic [c_ptr_w-1:0] w_top_inc;
    logic [c_ptr_w-1:0] w_top_dec;
    logic [c_ptr_w-1:0] w_wr_ptr;
    logic               w_pop;

    // A pop on an empty stack is dropped here as well, so push+pop on empty
    // degenerates to a plain push.
    assign w_pop     = pop && (r_count != '0);
    assign w_top_inc = r_top + c_ptr_w'(1);
    assign w_top_dec = r_top - c_ptr_w'(1);
    // push+pop replaces the current top; a plain push goes one slot above it.
    assign w_wr_ptr  = w_pop ? r_top : w_top_inc;

    // Pointer and occupancy bookkeeping; flush empties without touching data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (push && w_pop) begin
            r_top   <= r_top;
            r_count <= r_count;
        end else if (push) begin
            r_top <= w_top_inc;
            if (r_count != c_max_count) begin
                r_count <= r_count + c_cnt_w'(1);
            end
        end else if (w_pop) begin
            r_top   <= w_top_dec;
            r_count <= r_count - c_cnt_w'(1);
        end
    end

    // Entry storage needs no reset: validity is tracked entirely by r_count.
    always_ff @(posedge clock) begin
        if (!reset && !flush && push) begin
            r_mem[w_wr_ptr] <= push_data;
        end
    end

    assign top_data = r_mem[r_top];
    assign empty    = (r_count == '0);
    assign full     = (r_count == c_max_count);

endmodule : return_address_stack
`default_nettype wire

// File: rtl/program_counter_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : program_counter_unit
// Description : Fetch-stage program counter with boot handshake, stall hold,
//               branch/jump redirect, trap vectoring with misaligned-target
//               detection and return-address-stack call/return prediction.
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(c_default_reset_vector),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(c_default_trap_vector),
    parameter int unsigned     INC          = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic            pc_valid,
    output logic            misaligned,
    output logic            ras_empty,
    output logic            ras_full
);

    pc_state_t       r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_pc_valid;
    logic            r_misaligned;

    logic            w_run;
    logic            w_bad_redirect;
    logic            w_ras_update;
    logic            w_ras_push;
    logic            w_ras_pop;
    logic            w_ras_flush;
    logic            w_ras_empty;
    logic            w_ras_full;
    logic [XLEN-1:0] w_ras_top;
    logic [XLEN-1:0] w_pc_plus_inc;
    logic [XLEN-1:0] w_pc_next;
    pc_sel_t         w_sel;

    assign w_run          = (r_state == RUN);
    assign w_bad_redirect = redirect_valid && is_misaligned(redirect_target[1:0]);
    assign w_pc_plus_inc  = r_pc + XLEN'(INC);

    // The stack only moves on a clean sequential/return cycle; any trap or
    // misaligned redirect throws away predictions made on the wrong path.
    assign w_ras_update = w_run && !stall && !trap && !redirect_valid;
    assign w_ras_push   = w_ras_update && ras_push;
    assign w_ras_pop    = w_ras_update && ras_pop && !w_ras_empty;
    assign w_ras_flush  = w_run && (trap || w_bad_redirect);

    // Next-PC source selection: trap > redirect > stall > return > sequential.
    always_comb begin
        w_sel = SEL_SEQ;
        if (trap) begin
            w_sel = SEL_TRAP;
        end else if (redirect_valid) begin
            w_sel = w_bad_redirect ? SEL_TRAP : SEL_REDIR;
        end else if (stall) begin
            w_sel = SEL_HOLD;
        end else if (ras_pop && !w_ras_empty) begin
            w_sel = SEL_RAS;
        end
    end

    // Next-PC value for the selected source.
    always_comb begin
        w_pc_next = w_pc_plus_inc;
        case (w_sel)
            SEL_TRAP:  w_pc_next = TRAP_VECTOR;
            SEL_REDIR: w_pc_next = redirect_target;
            SEL_HOLD:  w_pc_next = r_pc;
            SEL_RAS:   w_pc_next = w_ras_top;
            SEL_SEQ:   w_pc_next = w_pc_plus_inc;
            default:   w_pc_next = w_pc_plus_inc;
        endcase
    end

    // Boot/run sequencer with registered PC, valid and misaligned pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= BOOT;
            r_pc         <= RESET_VECTOR;
            r_pc_valid   <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state      <= RUN;
                    r_pc         <= RESET_VECTOR;
                    r_pc_valid   <= 1'b1;
                    r_misaligned <= 1'b0;
                end
                RUN: begin
                    r_state      <= RUN;
                    r_pc         <= w_pc_next;
                    r_pc_valid   <= 1'b1;
                    // A simultaneous trap wins, so the redirect was not accepted.
                    r_misaligned <= w_bad_redirect && !trap;
                end
                default: begin
                    r_state      <= BOOT;
                    r_pc         <= RESET_VECTOR;
                    r_pc_valid   <= 1'b0;
                    r_misaligned <= 1'b0;
                end
            endcase
        end
    end

    return_address_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (w_ras_push),
        .pop       (w_ras_pop),
        .flush     (w_ras_flush),
        .push_data (w_pc_plus_inc),
        .top_data  (w_ras_top),
        .empty     (w_ras_empty),
        .full      (w_ras_full)
    );

    assign pc          = r_pc;
    assign pc_plus_inc = w_pc_plus_inc;
    assign pc_valid    = r_pc_valid;
    assign misaligned  = r_misaligned;
    assign ras_empty   = w_ras_empty;
    assign ras_full    = w_ras_full;

endmodule : program_counter_unit
`default_nettype wire
